// File: rtl/computer_player.sv
// Computer opponent for Tug of War: a divided-rate XNOR LFSR is added to the
// difficulty switches and the adder carry-out becomes a one-cycle press pulse.
module computer_player #(
   parameter int         TICK_DIV = 2**16,
   parameter logic [8:0] SEED     = 9'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       game_over,
   input  logic [8:0] difficulty,
   output logic       press,
   output logic [8:0] rand_value
);

   localparam int            CW        = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [8:0]    lfsr_q, lfsr_d;
   logic          press_q, press_d;
   logic          tick;
   logic          carry;

   always_comb begin
      tick    = (cnt_q == TICK_LAST);
      // Only the carry of the 9-bit add matters; it uses the pre-shift LFSR value.
      carry   = |(({1'b0, lfsr_q} + {1'b0, difficulty}) >> 4'd9);
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      lfsr_d  = lfsr_q;
      if (tick) begin
         lfsr_d = {lfsr_q[7:0], ~(lfsr_q[8] ^ lfsr_q[4])};
      end
      press_d = tick & enable & ~game_over & carry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         lfsr_q  <= SEED;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         press_q <= press_d;
      end
   end

   assign press      = press_q;
   assign rand_value = lfsr_q;

endmodule

// File: tb/tb_computer_player.sv
// Bench for computer_player (TICK_DIV=4, SEED=0): vector table, directed
// corner sequences and randomized inputs checked against a bit-stream model.
module tb_computer_player;

   localparam int         TICK_DIV = 4;
   localparam logic [8:0] SEED     = 9'd0;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       game_over;
   logic [8:0] difficulty;
   logic       press;
   logic [8:0] rand_value;

   computer_player #(.TICK_DIV(TICK_DIV), .SEED(SEED)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .game_over  (game_over),
      .difficulty (difficulty),
      .press      (press),
      .rand_value (rand_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int seen_1ff;
   int press_cnt;

   // Reference: the LFSR viewed as a bit stream, oldest bit first (hist[0] = bit 8).
   bit   hist[$];
   int   m_phase;
   logic m_press;

   function automatic logic [8:0] m_value();
      logic [8:0] v;
      for (int k = 0; k < 9; k++) v[8-k] = hist[k];
      return v;
   endfunction

   task automatic m_reset();
      hist.delete();
      for (int k = 8; k >= 0; k--) hist.push_back(SEED[k]);
      m_phase = 0;
      m_press = 1'b0;
   endtask

   task automatic m_update();
      bit         tick;
      logic [8:0] v;
      if (reset) begin
         m_reset();
      end else begin
         tick    = (m_phase == TICK_DIV - 1);
         v       = m_value();
         m_press = tick && enable && !game_over && ((int'(v) + int'(difficulty)) >= 512);
         if (tick) begin
            hist.push_back(~(hist[0] ^ hist[4]));
            void'(hist.pop_front());
         end
         m_phase = tick ? 0 : m_phase + 1;
      end
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      m_update();
      @(negedge clk);
      check("press_model", 16'(press), 16'(m_press));
      check("rand_model", 16'(rand_value), 16'(m_value()));
      if (rand_value == 9'h1FF) seen_1ff++;
      if (press) press_cnt++;
   endtask

   typedef struct {
      logic [8:0] diff;
      logic       en;
      logic       go;
      logic [8:0] exp_rand;
      logic       exp_press;
   } row_t;

   row_t rows[12];

   initial begin
      logic [8:0] pre;

      rows[0]  = '{9'd511, 1'b1, 1'b0, 9'h000, 1'b0};
      rows[1]  = '{9'd511, 1'b1, 1'b0, 9'h001, 1'b1};
      rows[2]  = '{9'd0,   1'b1, 1'b0, 9'h003, 1'b0};
      rows[3]  = '{9'd505, 1'b1, 1'b0, 9'h007, 1'b1};
      rows[4]  = '{9'd496, 1'b1, 1'b0, 9'h00F, 1'b0};
      rows[5]  = '{9'd481, 1'b0, 1'b0, 9'h01F, 1'b0};
      rows[6]  = '{9'd511, 1'b1, 1'b1, 9'h03E, 1'b0};
      rows[7]  = '{9'd511, 1'b1, 1'b0, 9'h07C, 1'b1};
      rows[8]  = '{9'd256, 1'b1, 1'b0, 9'h0F8, 1'b0};
      rows[9]  = '{9'd16,  1'b1, 1'b0, 9'h1F0, 1'b1};
      rows[10] = '{9'd31,  1'b1, 1'b0, 9'h1E1, 1'b1};
      rows[11] = '{9'd61,  1'b1, 1'b0, 9'h1C2, 1'b0};

      seen_1ff   = 0;
      press_cnt  = 0;
      reset      = 1'b1;
      enable     = 1'b0;
      game_over  = 1'b0;
      difficulty = 9'd0;
      m_reset();

      // Reset for two cycles, then walk the vector table one tick per row.
      step();
      step();
      check("reset_press", 16'(press), 16'h0);
      check("reset_rand", 16'(rand_value), 16'h000);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         difficulty = rows[i].diff;
         enable     = rows[i].en;
         game_over  = rows[i].go;
         for (int c = 0; c < TICK_DIV - 1; c++) begin
            step();
            if (i == 0) check("press_before_first_tick", 16'(press), 16'h0);
         end
         check("row_rand", 16'(rand_value), 16'(rows[i].exp_rand));
         step();
         check("row_press", 16'(press), 16'(rows[i].exp_press));
      end

      // difficulty 0 over more than a full period: no press, no 1FF, period 511.
      difficulty = 9'd0;
      enable     = 1'b1;
      game_over  = 1'b0;
      seen_1ff   = 0;
      press_cnt  = 0;
      pre        = m_value();
      for (int c = 0; c < 511 * TICK_DIV; c++) step();
      check("period_511", 16'(rand_value), 16'(pre));
      for (int c = 0; c < 2100 - 511 * TICK_DIV; c++) step();
      check("no_press_diff0", 16'(press_cnt), 16'd0);
      check("never_1ff", 16'(seen_1ff), 16'd0);

      // difficulty 256 over one full period: presses exactly on states 256..510.
      difficulty = 9'd256;
      press_cnt  = 0;
      for (int c = 0; c < 511 * TICK_DIV; c++) step();
      check("press_count_256", 16'(press_cnt), 16'd255);

      // game_over raised on the tick cycle, then enable dropped on a tick cycle.
      difficulty = 9'd511;
      for (int c = 0; c < TICK_DIV - 1; c++) step();
      game_over = 1'b1;
      pre       = m_value();
      step();
      check("game_over_on_tick", 16'(press), 16'h0);
      check("lfsr_steps_game_over", 16'(rand_value != pre), 16'h1);
      game_over = 1'b0;
      for (int c = 0; c < TICK_DIV - 1; c++) step();
      enable = 1'b0;
      pre    = m_value();
      step();
      check("enable_off_on_tick", 16'(press), 16'h0);
      check("lfsr_steps_disabled", 16'(rand_value != pre), 16'h1);
      enable = 1'b1;

      // Randomized inputs changing at arbitrary cycles, with occasional resets.
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) difficulty = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 5) == 0) enable = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) game_over = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 1'b0;

      // Reset landing on a tick cycle whose press would fire.
      reset = 1'b1;
      step();
      reset      = 1'b0;
      difficulty = 9'd511;
      enable     = 1'b1;
      game_over  = 1'b0;
      for (int c = 0; c < 2 * TICK_DIV + TICK_DIV - 1; c++) step();
      check("pre_reset_rand", 16'(rand_value), 16'h003);
      reset = 1'b1;
      step();
      check("reset_drops_press", 16'(press), 16'h0);
      check("reset_mid_rand", 16'(rand_value), 16'h000);
      reset = 1'b0;
      for (int c = 0; c < TICK_DIV - 1; c++) step();
      check("restart_no_early_tick", 16'(rand_value), 16'h000);
      step();
      check("restart_tick_rand", 16'(rand_value), 16'h001);
      check("restart_tick_press", 16'(press), 16'h0);
      step();
      check("post_restart_press", 16'(press), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
